// File: rtl/mc_sequencer.sv
// rtl/mc_sequencer.sv - microcode sequencer with opcode dispatch, step branching and NMI/IRQ entry
//
// Ports:
//   clk, RST            clock, asynchronous active-low reset
//   rdy                 1 = advance, 0 = hold
//   opcode              opcode to dispatch when mc_end=1
//   mc_end              current microword ends its sequence
//   mc_branch, cond     conditional step branch and its selected condition
//   br_step             branch target step
//   nmi_n               active-low NMI, falling-edge sensitive
//   irq_n, i_flag       active-low level IRQ and its mask
//   uaddr               microcode ROM address {base, step}
//   sync                opcode dispatch this cycle
//   irq_ack, nmi_ack    one-cycle pulses on interrupt sequence entry
//   seq_state           0 RESET, 1 RUN, 2 INT
//   step_err            sticky step overflow flag
module mc_sequencer #(
    parameter int              OPW    = 8,
    parameter int              STEPW  = 3,
    parameter logic [OPW-1:0]  RST_OP = 8'h02,
    parameter logic [OPW-1:0]  NMI_OP = 8'h12,
    parameter logic [OPW-1:0]  IRQ_OP = 8'h22,
    localparam int             AW     = OPW + STEPW
) (
    input  logic             clk,
    input  logic             RST,
    input  logic             rdy,
    input  logic [OPW-1:0]   opcode,
    input  logic             mc_end,
    input  logic             mc_branch,
    input  logic             cond,
    input  logic [STEPW-1:0] br_step,
    input  logic             nmi_n,
    input  logic             irq_n,
    input  logic             i_flag,
    output logic [AW-1:0]    uaddr,
    output logic             sync,
    output logic             irq_ack,
    output logic             nmi_ack,
    output logic [1:0]       seq_state,
    output logic             step_err
);

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_RUN   = 2'd1,
        S_INT   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [OPW-1:0]   base_q, base_d;
    logic [STEPW-1:0] step_q, step_d;
    logic             err_q, err_d;
    logic             nmi_q;
    logic             nmi_pend_q, nmi_pend_d;
    logic             nmi_ack_q, nmi_ack_d;
    logic             irq_ack_q, irq_ack_d;
    logic             irq_req;
    logic             take_nmi, take_irq, take_op;
    logic             nmi_edge;

    assign irq_req  = ~irq_n & ~i_flag;
    assign take_nmi = mc_end & nmi_pend_q;
    assign take_irq = mc_end & ~nmi_pend_q & irq_req;
    assign take_op  = mc_end & ~nmi_pend_q & ~irq_req;
    assign nmi_edge = nmi_q & ~nmi_n;

    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        step_d    = step_q;
        err_d     = err_q;
        // Acks are pulses: they drop after one cycle regardless of rdy.
        nmi_ack_d = 1'b0;
        irq_ack_d = 1'b0;
        // An edge seen in the dispatch cycle survives the clear below.
        nmi_pend_d = (nmi_pend_q & ~(rdy & take_nmi)) | nmi_edge;

        if (rdy) begin
            if (mc_end) begin
                step_d = '0;
                if (take_nmi) begin
                    base_d    = NMI_OP;
                    state_d   = S_INT;
                    nmi_ack_d = 1'b1;
                end else if (take_irq) begin
                    base_d    = IRQ_OP;
                    state_d   = S_INT;
                    irq_ack_d = 1'b1;
                end else begin
                    base_d  = opcode;
                    state_d = S_RUN;
                end
            end else if (mc_branch && cond) begin
                step_d = br_step;
            end else begin
                step_d = step_q + 1'b1;
                if (&step_q) begin
                    err_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            state_q    <= S_RESET;
            base_q     <= RST_OP;
            step_q     <= '0;
            err_q      <= 1'b0;
            nmi_q      <= 1'b1;
            nmi_pend_q <= 1'b0;
            nmi_ack_q  <= 1'b0;
            irq_ack_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            step_q     <= step_d;
            err_q      <= err_d;
            nmi_q      <= nmi_n;
            nmi_pend_q <= nmi_pend_d;
            nmi_ack_q  <= nmi_ack_d;
            irq_ack_q  <= irq_ack_d;
        end
    end

    assign uaddr     = {base_q, step_q};
    assign sync      = RST & rdy & take_op;
    assign nmi_ack   = nmi_ack_q;
    assign irq_ack   = irq_ack_q;
    assign seq_state = state_q;
    assign step_err  = err_q;

endmodule

// File: tb/tb_mc_sequencer.sv
// tb/tb_mc_sequencer.sv - scoreboard bench for mc_sequencer with directed vectors
module tb_mc_sequencer;

    logic        clk = 1'b0;
    logic        RST = 1'b0;
    logic        rdy = 1'b1;
    logic [7:0]  opcode = 8'h00;
    logic        mc_end = 1'b0;
    logic        mc_branch = 1'b0;
    logic        cond = 1'b0;
    logic [2:0]  br_step = 3'd0;
    logic        nmi_n = 1'b1;
    logic        irq_n = 1'b1;
    logic        i_flag = 1'b1;
    logic [10:0] uaddr;
    logic        sync, irq_ack, nmi_ack, step_err;
    logic [1:0]  seq_state;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [16:0] exp;
        string       name;
    } exp_t;

    exp_t sb[$];

    mc_sequencer dut (
        .clk(clk), .RST(RST), .rdy(rdy), .opcode(opcode), .mc_end(mc_end),
        .mc_branch(mc_branch), .cond(cond), .br_step(br_step), .nmi_n(nmi_n),
        .irq_n(irq_n), .i_flag(i_flag), .uaddr(uaddr), .sync(sync),
        .irq_ack(irq_ack), .nmi_ack(nmi_ack), .seq_state(seq_state),
        .step_err(step_err)
    );

    always #5 clk = ~clk;

    // Monitor: one expected entry per cycle, compared at the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                exp_t e;
                logic [16:0] got;
                e   = sb.pop_front();
                got = {uaddr, sync, nmi_ack, irq_ack, seq_state, step_err};
                checks++;
                if (got !== e.exp) begin
                    errors++;
                    $display("FAIL %s: got uaddr=%h sync=%b nack=%b iack=%b st=%0d err=%b, expected uaddr=%h sync=%b nack=%b iack=%b st=%0d err=%b",
                             e.name, got[16:6], got[5], got[4], got[3], got[2:1], got[0],
                             e.exp[16:6], e.exp[5], e.exp[4], e.exp[3], e.exp[2:1], e.exp[0]);
                end
            end
        end
    end

    // Drive one cycle of inputs and push the outputs expected during that cycle.
    task automatic cyc(input logic r, rd, e, b, c, input logic [2:0] bs,
                       input logic [7:0] op, input logic nm, iq, ifl,
                       input logic [10:0] ua, input logic sy, na, ia,
                       input logic [1:0] st, input logic er, input string nm_s);
        exp_t x;
        @(posedge clk);
        #1;
        RST = r; rdy = rd; mc_end = e; mc_branch = b; cond = c; br_step = bs;
        opcode = op; nmi_n = nm; irq_n = iq; i_flag = ifl;
        x.exp  = {ua, sy, na, ia, st, er};
        x.name = nm_s;
        sb.push_back(x);
    endtask

    initial begin
        //  RST rdy end br c bs  op     nmi irq ifl  uaddr    sy na ia st er
        cyc(0, 1, 0, 0, 0, 0, 8'h00, 1, 1, 1, 11'h010, 0, 0, 0, 0, 0, "reset_values");
        cyc(1, 1, 0, 0, 0, 0, 8'h00, 1, 1, 1, 11'h010, 0, 0, 0, 0, 0, "reset_step0");
        cyc(1, 1, 0, 0, 0, 0, 8'h00, 1, 1, 1, 11'h011, 0, 0, 0, 0, 0, "reset_step1");
        cyc(1, 1, 0, 0, 0, 0, 8'h00, 1, 1, 1, 11'h012, 0, 0, 0, 0, 0, "reset_step2");
        cyc(1, 1, 1, 0, 0, 0, 8'hA9, 1, 1, 1, 11'h013, 1, 0, 0, 0, 0, "dispatch_sync");
        cyc(1, 1, 0, 0, 0, 0, 8'h00, 1, 1, 1, 11'h548, 0, 0, 0, 1, 0, "a9_step0");
        cyc(1, 1, 0, 1, 1, 5, 8'h00, 1, 1, 1, 11'h549, 0, 0, 0, 1, 0, "branch_taken_at1");
        cyc(1, 1, 1, 1, 1, 2, 8'hA9, 1, 1, 1, 11'h54D, 1, 0, 0, 1, 0, "branch_landed5_end_wins");
        cyc(1, 1, 0, 0, 0, 0, 8'h00, 1, 1, 1, 11'h548, 0, 0, 0, 1, 0, "a9_again_step0");
        cyc(1, 1, 0, 1, 0, 5, 8'h00, 1, 1, 1, 11'h549, 0, 0, 0, 1, 0, "branch_not_taken");
        cyc(1, 1, 0, 0, 0, 0, 8'h00, 0, 0, 0, 11'h54A, 0, 0, 0, 1, 0, "step2_nmi_edge");
        cyc(1, 1, 1, 0, 0, 0, 8'hA9, 0, 0, 0, 11'h54B, 0, 0, 0, 1, 0, "end_with_nmi_pend");
        cyc(1, 1, 0, 0, 0, 0, 8'h00, 0, 0, 0, 11'h090, 0, 1, 0, 2, 0, "nmi_entry_ack");
        cyc(1, 1, 1, 0, 0, 0, 8'hA9, 0, 0, 0, 11'h091, 0, 0, 0, 2, 0, "nmi_end_irq_low");
        cyc(1, 1, 0, 0, 0, 0, 8'h00, 1, 0, 0, 11'h110, 0, 0, 1, 2, 0, "irq_entry_ack");
        cyc(1, 1, 1, 0, 0, 0, 8'hA9, 1, 1, 0, 11'h111, 1, 0, 0, 2, 0, "irq_released_opcode");
        cyc(1, 1, 0, 0, 0, 0, 8'h00, 1, 1, 1, 11'h548, 0, 0, 0, 1, 0, "back_to_a9");
        cyc(1, 0, 1, 0, 0, 0, 8'hA9, 1, 1, 1, 11'h549, 0, 0, 0, 1, 0, "hold_1");
        cyc(1, 0, 1, 0, 0, 0, 8'hA9, 0, 1, 1, 11'h549, 0, 0, 0, 1, 0, "hold_2_nmi_edge");
        cyc(1, 0, 1, 0, 0, 0, 8'hA9, 0, 1, 1, 11'h549, 0, 0, 0, 1, 0, "hold_3");
        cyc(1, 0, 1, 0, 0, 0, 8'hA9, 0, 1, 1, 11'h549, 0, 0, 0, 1, 0, "hold_4");
        cyc(1, 1, 1, 0, 0, 0, 8'hA9, 0, 1, 1, 11'h549, 0, 0, 0, 1, 0, "release_nmi_dispatch");
        cyc(1, 0, 0, 0, 0, 0, 8'h00, 1, 1, 1, 11'h090, 0, 1, 0, 2, 0, "nmi_ack_rdy_low");
        cyc(1, 1, 0, 0, 0, 0, 8'h00, 1, 1, 1, 11'h090, 0, 0, 0, 2, 0, "ack_one_cycle");
        for (int i = 1; i < 8; i++) begin
            cyc(1, 1, 0, 0, 0, 0, 8'h00, 1, 1, 1, 11'h090 + 11'(i), 0, 0, 0, 2, 0, "walk_steps");
        end
        cyc(1, 1, 0, 0, 0, 0, 8'h00, 1, 1, 1, 11'h090, 0, 0, 0, 2, 1, "wrap_step_err");
        cyc(1, 1, 1, 0, 0, 0, 8'hA9, 1, 0, 1, 11'h091, 1, 0, 0, 2, 1, "irq_masked_sync");
        cyc(1, 1, 0, 0, 0, 0, 8'h00, 0, 1, 1, 11'h548, 0, 0, 0, 1, 1, "nmi_edge_before_reset");
        cyc(0, 1, 0, 0, 0, 0, 8'h00, 1, 1, 1, 11'h010, 0, 0, 0, 0, 0, "mid_seq_reset");
        cyc(1, 1, 0, 0, 0, 0, 8'h00, 1, 1, 1, 11'h010, 0, 0, 0, 0, 0, "after_reset_step0");
        cyc(1, 1, 1, 0, 0, 0, 8'h5C, 1, 1, 1, 11'h011, 1, 0, 0, 0, 0, "no_nmi_survives");
        cyc(1, 1, 0, 0, 0, 0, 8'h00, 1, 1, 1, 11'h2E0, 0, 0, 0, 1, 0, "opcode_5c");

        for (int t = 0; t < 200 && sb.size() > 0; t++) begin
            @(posedge clk);
        end
        if (sb.size() > 0) begin
            errors++;
            checks++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
